// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port bundle between the MEM-stage controller (master) and the data memory (slave).
interface mem_stage_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores on a req/ready data port, stalls upstream, registers MEM/WB.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    mem_write_in,
  input  logic                    reg_write_in,
  input  logic [1:0]              mem_to_reg_in,
  input  logic [4:0]              rd_in,
  input  logic [31:0]             pc_count_in,
  input  logic [31:0]             rd2_in,
  input  logic [31:0]             alu_result_in,
  input  logic [31:0]             sign_imm_in,
  output logic                    stall_out,
  mem_stage_ctrl_if.master        dmem,
  output logic                    wb_valid,
  output logic                    wb_reg_write,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data,
  output logic                    mem_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;
  logic        mem_op;
  logic        done;
  logic        abort;

  logic [4:0]  rd_p0;
  logic        reg_write_p0;
  logic [1:0]  m2r_p0;

  function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                            input logic [31:0] alu,
                                            input logic [31:0] rdata,
                                            input logic [31:0] pc,
                                            input logic [31:0] imm);
    case (sel)
      2'b00:   return alu;
      2'b01:   return rdata;
      2'b10:   return pc + 32'd4;
      default: return imm;
    endcase
  endfunction

  // A load that also asserts mem_write is issued as a store.
  assign mem_op    = valid_in & (mem_write_in | (mem_to_reg_in == 2'b01));
  assign done      = (state == ACCESS) & dmem.dmem_ready;
  assign stall_out = mem_op & ~(done | abort);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Ready in the expiry cycle takes priority over the abort.
  assign abort = (state == ACCESS) & ~dmem.dmem_ready &
                 (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= abort;
      if (state == IDLE) tmo_cnt <= '0;
      else               tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign abort      = 1'b0;
  assign mem_err    = 1'b0;
`endif

  // Stage p0: instruction fields held for the duration of the access
  always_ff @(posedge clk) begin
    if ((state == IDLE) && mem_op) begin
      rd_p0        <= rd_in;
      reg_write_p0 <= reg_write_in;
      m2r_p0       <= mem_to_reg_in;
    end
  end

  // Stage p1: FSM, memory port and MEM/WB registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      wb_valid        <= 1'b0;
      wb_reg_write    <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state           <= ACCESS;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_write_in;
            dmem.dmem_addr  <= alu_result_in;
            dmem.dmem_wdata <= rd2_in;
            wb_valid        <= 1'b0;
            wb_reg_write    <= 1'b0;
          end else if (valid_in) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_in;
            wb_rd        <= rd_in;
            wb_data      <= wb_select(mem_to_reg_in, alu_result_in, dmem.dmem_rdata,
                                      pc_count_in, sign_imm_in);
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
        default: begin
          if (done) begin
            // EX/MEM is still held here, so its non-memory fields remain valid.
            state         <= IDLE;
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_reg_write  <= reg_write_p0;
            wb_rd         <= rd_p0;
            wb_data       <= wb_select(m2r_p0, alu_result_in, dmem.dmem_rdata,
                                       pc_count_in, sign_imm_in);
          end else if (abort) begin
            state         <= IDLE;
            dmem.dmem_req <= 1'b0;
            wb_valid      <= 1'b1;
            wb_reg_write  <= 1'b0;
            wb_rd         <= rd_p0;
          end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected MEM/WB results queued at issue, checked on wb output.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_write_in, reg_write_in;
  logic [1:0]  mem_to_reg_in;
  logic [4:0]  rd_in;
  logic [31:0] pc_count_in, rd2_in, alu_result_in, sign_imm_in;
  logic        stall_out;
  logic        wb_valid, wb_reg_write, mem_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage_ctrl_if dmem();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .mem_write_in  (mem_write_in),
    .reg_write_in  (reg_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .rd_in         (rd_in),
    .pc_count_in   (pc_count_in),
    .rd2_in        (rd2_in),
    .alu_result_in (alu_result_in),
    .sign_imm_in   (sign_imm_in),
    .stall_out     (stall_out),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        chk_data;
    logic        err;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every cycle the MEM/WB output must match the head of the scoreboard or be a bubble.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_eq("wb_valid", wb_valid, 1);
      check_eq("wb_rd", wb_rd, mon_e.rd);
      check_eq("wb_reg_write", wb_reg_write, mon_e.rw);
      check_eq("mem_err", mem_err, mon_e.err);
      if (mon_e.chk_data) check_eq("wb_data", wb_data, mon_e.data);
    end else begin
      check_eq("bubble_valid", wb_valid, 0);
      check_eq("bubble_reg_write", wb_reg_write, 0);
      check_eq("bubble_mem_err", mem_err, 0);
    end
  end

  task automatic set_instr(input logic we, input logic [1:0] m2r, input logic [31:0] alu,
                           input logic [31:0] wdata, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [4:0] rd, input logic rw);
    valid_in      = 1'b1;
    mem_write_in  = we;
    mem_to_reg_in = m2r;
    alu_result_in = alu;
    rd2_in        = wdata;
    pc_count_in   = pc;
    sign_imm_in   = imm;
    rd_in         = rd;
    reg_write_in  = rw;
  endtask

  task automatic idle(input int n);
    valid_in     = 1'b0;
    mem_write_in = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_eq("idle_stall", stall_out, 0);
      check_eq("idle_req", dmem.dmem_req, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic alu_op(input logic [1:0] m2r, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rd, input logic rw,
                        input logic [31:0] exp_data);
    set_instr(1'b0, m2r, alu, 32'h0, pc, imm, rd, rw);
    @(negedge clk);
    check_eq("alu_stall", stall_out, 0);
    check_eq("alu_req", dmem.dmem_req, 0);
    #1 exp_q.push_back(wb_exp_t'{rd, exp_data, rw, 1'b1, 1'b0});
    @(posedge clk); #1;
  endtask

  task automatic mem_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int lat, input logic [4:0] rd,
                         input logic rw, input logic [31:0] exp_data);
    set_instr(we, we ? 2'b00 : 2'b01, addr, wdata, 32'h0000_1000, 32'h0000_0055, rd, rw);
    @(negedge clk);
    check_eq("issue_stall", stall_out, 1);
    check_eq("issue_req", dmem.dmem_req, 0);
    @(posedge clk); #1;
    for (int i = 1; i <= lat; i++) begin
      dmem.dmem_ready = (i == lat);
      dmem.dmem_rdata = (i == lat) ? rdata : (32'h0BAD_0000 | i);
      @(negedge clk);
      check_eq("acc_req", dmem.dmem_req, 1);
      check_eq("acc_we", dmem.dmem_we, we);
      check_eq("acc_addr", dmem.dmem_addr, addr);
      if (we) check_eq("acc_wdata", dmem.dmem_wdata, wdata);
      check_eq("acc_stall", stall_out, (i != lat));
      if (i == lat) #1 exp_q.push_back(wb_exp_t'{rd, exp_data, rw, 1'b1, 1'b0});
      @(posedge clk); #1;
      dmem.dmem_ready = 1'b0;
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic timeout_load();
    set_instr(1'b0, 2'b01, 32'h0000_0300, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1);
    dmem.dmem_ready = 1'b0;
    @(negedge clk);
    check_eq("tmo_issue_stall", stall_out, 1);
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check_eq("tmo_req", dmem.dmem_req, 1);
      check_eq("tmo_stall", stall_out, (i != 16));
      if (i == 16) #1 exp_q.push_back(wb_exp_t'{5'd9, 32'h0, 1'b0, 1'b0, 1'b1});
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    set_instr(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    valid_in        = 1'b0;
    dmem.dmem_ready = 1'b0;
    dmem.dmem_rdata = 32'h0;
    #3;
    check_eq("rst_req", dmem.dmem_req, 0);
    check_eq("rst_addr", dmem.dmem_addr, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_stall", stall_out, 0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    alu_op(2'b00, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234);
    idle(1);
    mem_txn(1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 5'd7, 1'b1, 32'hDEAD_BEEF);
    idle(1);
    mem_txn(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 1, 5'd3, 1'b0, 32'h0000_0200);
    alu_op(2'b10, 32'h0, 32'h0000_0040, 32'h0, 5'd1, 1'b1, 32'h0000_0044);
    alu_op(2'b11, 32'h0, 32'h0, 32'hFFFF_FF80, 5'd2, 1'b1, 32'hFFFF_FF80);
    alu_op(2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd4, 1'b1, 32'h0000_0000);
    mem_txn(1'b0, 32'h0000_0400, 32'h0, 32'h1111_2222, 1, 5'd10, 1'b1, 32'h1111_2222);
    mem_txn(1'b0, 32'h0000_0404, 32'h0, 32'h3333_4444, 1, 5'd11, 1'b1, 32'h3333_4444);
    mem_txn(1'b1, 32'h0000_0500, 32'h1357_9BDF, 32'h0, 3, 5'd12, 1'b0, 32'h0000_0500);

    // Ready while idle must not create a write-back.
    dmem.dmem_ready = 1'b1;
    dmem.dmem_rdata = 32'h7777_7777;
    idle(2);
    dmem.dmem_ready = 1'b0;

    // Asynchronous reset while a load is outstanding.
    set_instr(1'b0, 2'b01, 32'h0000_0600, 32'h0, 32'h0, 32'h0, 5'd13, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("pre_rst_req", dmem.dmem_req, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_req", dmem.dmem_req, 0);
    check_eq("mid_rst_addr", dmem.dmem_addr, 0);
    check_eq("mid_rst_wb_valid", wb_valid, 0);
    check_eq("mid_rst_wb_rd", wb_rd, 0);
    check_eq("mid_rst_wb_data", wb_data, 0);
    valid_in = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    idle(1);
    alu_op(2'b00, 32'hA5A5_0001, 32'h0, 32'h0, 5'd14, 1'b1, 32'hA5A5_0001);

`ifdef MEM_TIMEOUT_EN
    timeout_load();
    idle(1);
    mem_txn(1'b0, 32'h0000_0700, 32'h0, 32'h2468_ACE0, 16, 5'd15, 1'b1, 32'h2468_ACE0);
`endif

    idle(2);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
